// File: rtl/dict_bank_ram.sv
// Bank-interleaved single-port dictionary RAM with registered read, read-valid
// strobe and a row-parallel clear sequencer that wipes all banks in ROWS cycles.
module dict_bank_ram #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 12,
  parameter int                BANK_BITS = 3,
  parameter logic [DATA_W-1:0] CLR_VAL   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              acc_drop
);

  localparam int NBANK = 1 << BANK_BITS;
  localparam int ROW_W = ADDR_W - BANK_BITS;
  localparam int ROWS  = 1 << ROW_W;
  localparam logic [ROW_W-1:0] LAST_ROW = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t               state_q;
  logic [ROW_W-1:0]     cnt_q;
  logic                 done_q;
  logic                 drop_q;
  logic                 vld_q;
  logic [BANK_BITS-1:0] sel_q;

  logic [BANK_BITS-1:0] bank_w;
  logic [ROW_W-1:0]     row_w;
  logic                 clearing_w;
  logic                 rd_acc_w;
  logic                 wr_acc_w;
  logic [ROW_W-1:0]     mem_row_w;
  logic [DATA_W-1:0]    mem_data_w;

  logic [NBANK-1:0][DATA_W-1:0] bank_rd_w;

  assign bank_w     = addr[BANK_BITS-1:0];
  assign row_w      = addr[ADDR_W-1:BANK_BITS];
  assign clearing_w = (state_q == CLEAR);
  assign rd_acc_w   = en & ~wren & ~clearing_w;
  assign wr_acc_w   = en &  wren & ~clearing_w;

  // The clear sequencer steals the shared row/data buses and writes every bank at once.
  assign mem_row_w  = clearing_w ? cnt_q   : row_w;
  assign mem_data_w = clearing_w ? CLR_VAL : wr_data;

  for (genvar k = 0; k < NBANK; k++) begin : g_bank
    logic [DATA_W-1:0] mem [ROWS];
    logic [DATA_W-1:0] rd_q;
    logic              we_w;
    logic              re_w;

    assign we_w = clearing_w | (wr_acc_w & (bank_w == BANK_BITS'(k)));
    assign re_w = rd_acc_w & (bank_w == BANK_BITS'(k));

    always_ff @(posedge clk) begin
      if (we_w) begin
        mem[mem_row_w] <= mem_data_w;
      end
    end

    // Each bank keeps its last read word, so the output mux holds rd_data between reads.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= '0;
      end else if (re_w) begin
        rd_q <= mem[row_w];
      end
    end

    assign bank_rd_w[k] = rd_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      vld_q   <= 1'b0;
      sel_q   <= '0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      vld_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_acc_w) begin
            vld_q <= 1'b1;
            sel_q <= bank_w;
          end
          if (clr_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          drop_q <= en;
          cnt_q  <= cnt_q + ROW_W'(1);
          if (cnt_q == LAST_ROW) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign rd_data  = bank_rd_w[sel_q];
  assign rd_valid = vld_q;
  assign clr_busy = clearing_w;
  assign clr_done = done_q;
  assign acc_drop = drop_q;

endmodule

// File: tb/tb_dict_bank_ram.sv
// Bench for dict_bank_ram: two configurations share one stimulus stream and are
// checked every cycle against an entry-level behavioural model plus literal checks.
module tb_dict_bank_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        wren = 1'b0;
  logic [11:0] addr = '0;
  logic [7:0]  wr_data = '0;
  logic        clr_start = 1'b0;

  logic [7:0] rd0, rd1;
  logic       vld0, vld1, busy0, busy1, done0, done1, drop0, drop1;

  dict_bank_ram u_a (
    .clk(clk), .rst(rst), .en(en), .wren(wren), .addr(addr), .wr_data(wr_data),
    .rd_data(rd0), .rd_valid(vld0), .clr_start(clr_start), .clr_busy(busy0),
    .clr_done(done0), .acc_drop(drop0)
  );

  dict_bank_ram #(.BANK_BITS(2), .CLR_VAL(8'hFF)) u_b (
    .clk(clk), .rst(rst), .en(en), .wren(wren), .addr(addr), .wr_data(wr_data),
    .rd_data(rd1), .rd_valid(vld1), .clr_start(clr_start), .clr_busy(busy1),
    .clr_done(done1), .acc_drop(drop1)
  );

  always #5 clk = ~clk;

  logic [7:0] o_rd   [2];
  logic       o_vld  [2];
  logic       o_busy [2];
  logic       o_done [2];
  logic       o_drop [2];
  always_comb begin
    o_rd[0] = rd0;   o_rd[1] = rd1;
    o_vld[0] = vld0; o_vld[1] = vld1;
    o_busy[0] = busy0; o_busy[1] = busy1;
    o_done[0] = done0; o_done[1] = done1;
    o_drop[0] = drop0; o_drop[1] = drop1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d] got=0x%0h want=0x%0h at %0t", nm, inst, act, exp, $time);
  endtask

  // Entry-level model: whole-memory array, clear as a countdown of busy cycles.
  int         m_rows [2] = '{512, 1024};
  logic [7:0] m_clr  [2] = '{8'h00, 8'hFF};
  logic [7:0] m_mem  [2][4096];
  bit         m_known[2][4096];
  int         m_busy [2] = '{0, 0};
  logic [7:0] m_rd   [2] = '{8'h00, 8'h00};
  bit         m_rdk  [2] = '{1'b0, 1'b0};
  bit         m_vld  [2] = '{1'b0, 1'b0};
  bit         m_done [2] = '{1'b0, 1'b0};
  bit         m_drop [2] = '{1'b0, 1'b0};

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        if (m_busy[i] > 0)
          for (int a = 0; a < 4096; a++) m_known[i][a] = 1'b0;
        m_busy[i] = 0;
        m_rd[i] = 8'h00; m_rdk[i] = 1'b1;
        m_vld[i] = 1'b0; m_done[i] = 1'b0; m_drop[i] = 1'b0;
      end else begin
        m_vld[i] = 1'b0; m_done[i] = 1'b0; m_drop[i] = 1'b0;
        if (m_busy[i] > 0) begin
          m_drop[i] = en;
          m_busy[i]--;
          if (m_busy[i] == 0) begin
            m_done[i] = 1'b1;
            for (int a = 0; a < 4096; a++) begin
              m_mem[i][a] = m_clr[i];
              m_known[i][a] = 1'b1;
            end
          end
        end else begin
          if (en && wren) begin
            m_mem[i][addr] = wr_data;
            m_known[i][addr] = 1'b1;
          end else if (en) begin
            m_rd[i] = m_mem[i][addr];
            m_rdk[i] = m_known[i][addr];
            m_vld[i] = 1'b1;
          end
          if (clr_start) m_busy[i] = m_rows[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("cyc_rd_valid", i, int'(o_vld[i]), int'(m_vld[i]));
        chk("cyc_clr_busy", i, int'(o_busy[i]), int'(m_busy[i] != 0));
        chk("cyc_clr_done", i, int'(o_done[i]), int'(m_done[i]));
        chk("cyc_acc_drop", i, int'(o_drop[i]), int'(m_drop[i]));
        if (m_rdk[i]) chk("cyc_rd_data", i, int'(o_rd[i]), int'(m_rd[i]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic w, input logic [11:0] a, input logic [7:0] d);
    en = 1'b1; wren = w; addr = a; wr_data = d;
    cyc();
    en = 1'b0; wren = 1'b0;
  endtask

  task automatic outs_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_rd_data"}, i, int'(o_rd[i]), 0);
      chk({nm, "_rd_valid"}, i, int'(o_vld[i]), 0);
      chk({nm, "_clr_busy"}, i, int'(o_busy[i]), 0);
      chk({nm, "_clr_done"}, i, int'(o_done[i]), 0);
      chk({nm, "_acc_drop"}, i, int'(o_drop[i]), 0);
    end
  endtask

  function automatic logic [7:0] fill_val(input int a);
    return 8'(a * 37 + 11);
  endfunction

  int busy_n [2];
  int done_n [2];
  int drop_n [2];

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    outs_zero("reset");
    rst = 1'b0;
    cyc();

    // Sixteen writes, then sixteen back-to-back reads across every bank.
    for (int a = 0; a < 16; a++) acc(1'b1, 12'(a), 8'(a + 'h40));
    for (int a = 0; a < 16; a++) begin
      acc(1'b0, 12'(a), 8'h00);
      chk("seq_rd_data", 0, int'(rd0), a + 'h40);
      chk("seq_rd_data", 1, int'(rd1), a + 'h40);
      chk("seq_rd_valid", 0, int'(vld0), 1);
    end

    // Read then idle: data held, strobe only once.
    acc(1'b1, 12'h123, 8'hA5);
    acc(1'b0, 12'h123, 8'h00);
    chk("hold_first", 0, int'(rd0), 'hA5);
    chk("hold_first_vld", 0, int'(vld0), 1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_rd_data", 0, int'(rd0), 'hA5);
      chk("hold_rd_data", 1, int'(rd1), 'hA5);
      chk("hold_rd_valid", 0, int'(vld0), 0);
    end

    // Read-after-write at the very next edge.
    acc(1'b1, 12'h7FF, 8'h3C);
    acc(1'b0, 12'h7FF, 8'h00);
    chk("raw_7ff", 0, int'(rd0), 'h3C);
    chk("raw_7ff", 1, int'(rd1), 'h3C);

    // Fill everything, clear, poke reads and a second start during the clear.
    for (int a = 0; a < 4096; a++) acc(1'b1, 12'(a), fill_val(a));
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    for (int i = 0; i < 2; i++) begin busy_n[i] = 0; done_n[i] = 0; drop_n[i] = 0; end
    for (int c = 0; c < 1200; c++) begin
      for (int i = 0; i < 2; i++) begin
        busy_n[i] += int'(o_busy[i]);
        done_n[i] += int'(o_done[i]);
        drop_n[i] += int'(o_drop[i]);
      end
      en = (c >= 10 && c < 20);
      wren = 1'b0;
      addr = 12'(c);
      clr_start = (c == 200);
      cyc();
    end
    en = 1'b0; clr_start = 1'b0;
    chk("clr_busy_len", 0, busy_n[0], 512);
    chk("clr_busy_len", 1, busy_n[1], 1024);
    chk("clr_done_cnt", 0, done_n[0], 1);
    chk("clr_done_cnt", 1, done_n[1], 1);
    chk("drop_cnt", 0, drop_n[0], 10);
    chk("drop_cnt", 1, drop_n[1], 10);
    chk("clr_rd_held", 0, int'(rd0), 'h3C);
    chk("clr_rd_held", 1, int'(rd1), 'h3C);
    for (int a = 0; a < 4096; a++) begin
      acc(1'b0, 12'(a), 8'h00);
      chk("clr_val", 0, int'(rd0), 'h00);
      chk("clr_val", 1, int'(rd1), 'hFF);
    end

    // Reset 100 cycles into a clear.
    clr_start = 1'b1;
    cyc();
    clr_start = 1'b0;
    repeat (100) cyc();
    chk("pre_rst_busy", 0, int'(busy0), 1);
    rst = 1'b1;
    #1;
    outs_zero("midclr_rst");
    cyc();
    rst = 1'b0;
    cyc();
    chk("post_rst_busy", 0, int'(busy0), 0);
    chk("post_rst_busy", 1, int'(busy1), 0);
    acc(1'b1, 12'h055, 8'h99);
    acc(1'b0, 12'h055, 8'h00);
    chk("post_rst_rd", 0, int'(rd0), 'h99);
    chk("post_rst_rd", 1, int'(rd1), 'h99);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached before end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
